// File: rtl/mac_pe_if.sv
// Operand/forward/result bundle for one systolic MAC processing element.
// slave = the PE's view; master = the driver/consumer's view.
interface mac_pe_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_in;
  logic signed [DATA_W-1:0] b_in;
  logic                     first_in;
  logic                     last_in;
  logic signed [DATA_W-1:0] a_out;
  logic signed [DATA_W-1:0] b_out;
  logic                     first_out;
  logic                     last_out;
  logic                     fwd_valid;
  logic signed [ACC_W-1:0]  res_data;
  logic                     res_sat;
  logic                     res_valid;
  logic                     res_ready;

  modport slave (
    input  in_valid, a_in, b_in, first_in, last_in, res_ready,
    output in_ready, a_out, b_out, first_out, last_out, fwd_valid,
           res_data, res_sat, res_valid
  );

  modport master (
    output in_valid, a_in, b_in, first_in, last_in, res_ready,
    input  in_ready, a_out, b_out, first_out, last_out, fwd_valid,
           res_data, res_sat, res_valid
  );
endinterface

// File: rtl/mac_pe.sv
// Two-stage signed multiply-accumulate PE with operand forwarding and a held result.
// Define MAC_PE_SAT_EN for a saturating accumulate with a sticky res_sat flag.
module mac_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  mac_pe_if.slave bus
);
  logic                       adv;
  logic                       accept;
  logic signed [2*DATA_W-1:0] prod;
  logic                       s1_v;
  logic                       s1_first;
  logic                       s1_last;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    p;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       sticky_next;

  // A held, unconsumed result freezes the whole PE.
  assign adv          = !bus.res_valid || bus.res_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

`ifdef MAC_PE_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sticky;
  logic ovf;

  always_comb begin
    p           = prod;
    base        = s1_first ? '0 : acc;
    sum         = base + p;
    ovf         = (base[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != p[ACC_W-1]);
    acc_next    = sum;
    sticky_next = s1_first ? 1'b0 : sticky;
    if (ovf) begin
      acc_next    = p[ACC_W-1] ? ACC_MIN : ACC_MAX;
      sticky_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
    end else if (adv && s1_v) begin
      sticky <= sticky_next;
    end
  end
`else
  always_comb begin
    p           = prod;
    base        = s1_first ? '0 : acc;
    sum         = base + p;
    acc_next    = sum;
    sticky_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_v <= accept;
      if (accept) begin
        prod     <= bus.a_in * bus.b_in;
        s1_first <= bus.first_in;
        s1_last  <= bus.last_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      bus.res_data  <= '0;
      bus.res_sat   <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      if (adv && s1_v) begin
        acc <= acc_next;
      end
      if (adv && s1_v && s1_last) begin
        bus.res_data  <= acc_next;
        bus.res_sat   <= sticky_next;
        bus.res_valid <= 1'b1;
      end else if (bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.first_out <= 1'b0;
      bus.last_out  <= 1'b0;
      bus.fwd_valid <= 1'b0;
    end else begin
      bus.fwd_valid <= adv && accept;
      if (accept) begin
        bus.a_out     <= bus.a_in;
        bus.b_out     <= bus.b_in;
        bus.first_out <= bus.first_in;
        bus.last_out  <= bus.last_in;
      end
    end
  end
endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: reset, dot products, stall, overflow, mid-run reset, back-to-back.
module tb_mac_pe;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b, input logic f, input logic l);
    bus.in_valid = v;
    bus.a_in     = DATA_W'(a);
    bus.b_in     = DATA_W'(b);
    bus.first_in = f;
    bus.last_in  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.res_ready = 1'b0;
    drive(1'b1, 9, 9, 1'b1, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_sat, bus.fwd_valid, bus.first_out, bus.last_out,
         bus.a_out, bus.b_out, bus.res_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rv=%b rs=%b fv=%b a=%h b=%h d=%h want all 0",
               bus.res_valid, bus.res_sat, bus.fwd_valid, bus.a_out, bus.b_out, bus.res_data);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.fwd_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_idle: got rv=%b fv=%b want 0 0", bus.res_valid, bus.fwd_valid);
    end
  endtask

  task automatic test_dot_product();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i + 1, i + 5, (i == 0), (i == 3));
      tick();
      n_cmp++;
      if ({bus.fwd_valid, bus.a_out, bus.b_out, bus.first_out, bus.last_out} !==
          {1'b1, DATA_W'(i + 1), DATA_W'(i + 5), (i == 0), (i == 3)}) begin
        n_err++;
        $display("FAIL dot_fwd[%0d]: got fv=%b a=%0d b=%0d f=%b l=%b want 1 %0d %0d %b %b", i,
                 bus.fwd_valid, bus.a_out, bus.b_out, bus.first_out, bus.last_out,
                 i + 1, i + 5, (i == 0), (i == 3));
      end
      n_cmp++;
      if (bus.res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dot_early_valid[%0d]: got %b want 0", i, bus.res_valid);
      end
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_data, bus.fwd_valid} !== {1'b1, ACC_W'(70), 1'b0}) begin
      n_err++;
      $display("FAIL dot_result: got v=%b d=%0d fv=%b want 1 70 0",
               bus.res_valid, bus.res_data, bus.fwd_valid);
    end
    tick();
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dot_valid_drop: got %b want 0", bus.res_valid);
    end
  endtask

  task automatic test_single_beat();
    bus.res_ready = 1'b1;
    drive(1'b1, -3, 7, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: got %b want 0", bus.res_valid);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_sat, bus.res_data} !== {1'b1, 1'b0, 32'hFFFF_FFEB}) begin
      n_err++;
      $display("FAIL single_result: got v=%b s=%b d=%h want 1 0 ffffffeb",
               bus.res_valid, bus.res_sat, bus.res_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    drive(1'b1, 2, 3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1, 5, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_data, bus.in_ready} !== {1'b1, ACC_W'(6), 1'b0}) begin
      n_err++;
      $display("FAIL bp_first_result: got v=%b d=%0d ir=%b want 1 6 0",
               bus.res_valid, bus.res_data, bus.in_ready);
    end
    drive(1'b1, 2, 6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.in_ready, bus.fwd_valid, bus.res_valid, bus.a_out, bus.res_data} !==
          {1'b0, 1'b0, 1'b1, DATA_W'(1), ACC_W'(6)}) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got ir=%b fv=%b v=%b a=%0d d=%0d want 0 0 1 1 6", k,
                 bus.in_ready, bus.fwd_valid, bus.res_valid, bus.a_out, bus.res_data);
      end
    end
    bus.res_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.fwd_valid, bus.a_out} !== {1'b0, 1'b1, DATA_W'(2)}) begin
      n_err++;
      $display("FAIL bp_resume: got v=%b fv=%b a=%0d want 0 1 2",
               bus.res_valid, bus.fwd_valid, bus.a_out);
    end
    drive(1'b1, 3, 7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4, 8, 1'b0, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_data} !== {1'b1, ACC_W'(70)}) begin
      n_err++;
      $display("FAIL bp_second_result: got v=%b d=%0d want 1 70", bus.res_valid, bus.res_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] exp_d;
    logic             exp_s;
`ifdef MAC_PE_SAT_EN
    exp_d = 32'h7FFF_FFFF;
    exp_s = 1'b1;
`else
    // 3 * 2^30 wraps modulo 2^32
    exp_d = 32'hC000_0000;
    exp_s = 1'b0;
`endif
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, -32768, -32768, (i == 0), (i == 2));
      tick();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_sat, bus.res_data} !== {1'b1, exp_s, exp_d}) begin
      n_err++;
      $display("FAIL overflow: got v=%b s=%b d=%h want 1 %b %h",
               bus.res_valid, bus.res_sat, bus.res_data, exp_s, exp_d);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b1;
    drive(1'b1, 1, 5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2, 6, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if ({bus.res_valid, bus.res_sat, bus.fwd_valid, bus.first_out, bus.last_out,
         bus.a_out, bus.b_out, bus.res_data} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got fv=%b a=%0d b=%0d d=%0d want all 0",
               bus.fwd_valid, bus.a_out, bus.b_out, bus.res_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    // no first tag: result only equals 70 if the partial sum was discarded
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i + 1, i + 5, 1'b0, (i == 3));
      tick();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.res_valid, bus.res_data} !== {1'b1, ACC_W'(70)}) begin
      n_err++;
      $display("FAIL midreset_result: got v=%b d=%0d want 1 70", bus.res_valid, bus.res_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   av [0:6] = '{1, 2, 3, 4, -3, 5, 6};
    int   bv [0:6] = '{5, 6, 7, 8, 7, 5, 1};
    logic fv [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic lv [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_v [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_d [0:8] = '{0, 0, 0, 0, 70, -21, 0, 31, 0};
    bus.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) drive(1'b1, av[i], bv[i], fv[i], lv[i]);
      else drive(1'b0, 0, 0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (bus.res_valid !== exp_v[i]) begin
        n_err++;
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, bus.res_valid, exp_v[i]);
      end
      if (exp_v[i]) begin
        n_cmp++;
        if ({bus.res_sat, bus.res_data} !== {1'b0, ACC_W'(exp_d[i])}) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got s=%b d=%0d want 0 %0d", i,
                   bus.res_sat, bus.res_data, exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dot_product();
    test_single_beat();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
